clk_div_gen: RTL and testbench

Parametrised multi-channel clock divider and enable generator. It is the successor to the fixed divide-by-4 processor/regfile clock divider. The block produces NUM_CH independent divided clocks, each with a matching single-cycle tick enable. Each channel's divide ratio is programmable at runtime through a valid/ready config port, and new ratios take effect only at a period boundary so no runt pulses are produced. It sits in the top-level wrapper and feeds the processor, regfile and any slower peripheral clock domains.

---
 rtl/clk_div_gen.sv | 137 +++++++++++++
 tb/tb_clk_div_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock divider and tick generator.
//
// Each of NUM_CH channels produces a registered divided clock (clk_out) and
// a one-cycle tick at the start of every period. The divide ratio of each
// channel is written through a single-entry valid/ready config port. A
// written ratio is held in a pending slot and only takes effect at the
// target channel's period boundary, so reconfiguration never produces a
// runt pulse.
//
// Ports:
//   clock      input clock, all state on posedge
//   reset      asynchronous active-low reset
//   cfg_valid  config request
//   cfg_ready  pending slot free (transfer on cfg_valid & cfg_ready)
//   cfg_ch     target channel (values >= NUM_CH are consumed and dropped)
//   cfg_div    new divide ratio (0 = stop, 1 = pass-through high)
//   clk_out    divided clocks, registered
//   tick       period-start pulses, registered
//   active     channel running (div != 0)
//
// Build option: define CLKDIV_ALIGN_EN to restart every running channel in
// phase with the reconfigured channel on the apply edge.

module clk_div_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active
);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  div_n [NUM_CH];
  logic [CNT_W-1:0]  cnt_n [NUM_CH];
  logic [NUM_CH-1:0] clk_n;
  logic [NUM_CH-1:0] tick_n;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] hit;
  logic              apply_any;

  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_div;
  logic              ch_ok;

  assign cfg_ready = ~pend_valid;

  // Channel range check is only needed when cfg_ch can encode unused values.
  generate
    if (NUM_CH < (1 << CH_W)) begin : g_ch_chk
      always_comb ch_ok = (cfg_ch < CH_W'(NUM_CH));
    end else begin : g_ch_all
      always_comb ch_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      active[i] = (div_q[i] != '0);
      wrap[i]   = (div_q[i] >= CNT_W'(2)) && (cnt_q[i] == div_q[i] - CNT_W'(1));
      // Stopped and div-1 channels have no period boundary, so they take
      // the pending ratio on the first edge it is visible.
      hit[i]    = pend_valid && (pend_ch == CH_W'(i)) &&
                  (wrap[i] || (div_q[i] <= CNT_W'(1)));
    end
    apply_any = |hit;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      div_n[i]  = div_q[i];
      cnt_n[i]  = '0;
      clk_n[i]  = 1'b0;
      tick_n[i] = 1'b0;
      if (hit[i]) begin
        div_n[i]  = pend_div;
        clk_n[i]  = (pend_div != '0);
        tick_n[i] = (pend_div != '0);
`ifdef CLKDIV_ALIGN_EN
      end else if (apply_any && (div_q[i] != '0)) begin
        clk_n[i]  = 1'b1;
        tick_n[i] = 1'b1;
`endif
      end else if (div_q[i] == '0) begin
        clk_n[i]  = 1'b0;
        tick_n[i] = 1'b0;
      end else if (div_q[i] == CNT_W'(1)) begin
        clk_n[i]  = 1'b1;
        tick_n[i] = 1'b1;
      end else begin
        cnt_n[i]  = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
        // High length is ceil(div/2), so odd ratios keep the longer phase high.
        clk_n[i]  = (cnt_n[i] < ((div_q[i] >> 1) + CNT_W'(div_q[i][0])));
        tick_n[i] = wrap[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i] <= CNT_W'(DEFAULT_DIV);
        cnt_q[i] <= CNT_W'(DEFAULT_DIV - 1);
      end
      clk_out    <= '0;
      tick       <= '0;
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_n[i];
        cnt_q[i] <= cnt_n[i];
      end
      clk_out <= clk_n;
      tick    <= tick_n;
      if (apply_any) begin
        pend_valid <= 1'b0;
      end else if (cfg_valid && cfg_ready && ch_ok) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_div   <= cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed self-checking bench for clk_div_gen.
// Main instance uses NUM_CH=4; a second NUM_CH=5 instance has a 3-bit
// channel select so an out-of-range channel (7) can be presented.

module tb_clk_div_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic [3:0] clk_out, tick, active;

  logic       cfg_valid2 = 1'b0;
  logic [2:0] cfg_ch2 = '0;
  logic [7:0] cfg_div2 = '0;
  logic       cfg_ready2;
  logic [4:0] clk_out2, tick2, active2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clk_div_gen #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(4)) u_dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick),
    .active(active)
  );

  clk_div_gen #(.NUM_CH(5), .CNT_W(8), .DEFAULT_DIV(4)) u_inv (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_ch(cfg_ch2), .cfg_div(cfg_div2), .clk_out(clk_out2), .tick(tick2),
    .active(active2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Default divide-by-4 pattern: edge k after reset release (k >= 1).
  function automatic logic def_clk(input int k);
    return ((k - 1) % 4) < 2;
  endfunction

  function automatic logic def_tick(input int k);
    return ((k - 1) % 4) == 0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    cfg_valid = 1'b0;
    cfg_valid2 = 1'b0;
    step();
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_active", 32'(active), 32'hF);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    reset = 1'b1;
  endtask

  initial begin
    logic [9:0]  t2_clk;
    logic [9:0]  t2_tick;
    logic [3:0]  t3_clk;
    logic [3:0]  t3_tick;
    logic [11:0] t4_clk;
    logic [11:0] t4_tick;
    logic [11:0] t4_rdy;
    logic [3:0]  dv;
    logic [4:0]  dv5;

    // 1. defaults after reset release
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      dv = {4{def_clk(k)}};
      chk("t1_clk", 32'(clk_out), 32'(dv));
      dv = {4{def_tick(k)}};
      chk("t1_tick", 32'(tick), 32'(dv));
      chk("t1_active", 32'(active), 32'hF);
      chk("t1_ready", 32'(cfg_ready), 32'h1);
    end

    // 2. odd ratio on ch1, written at cnt=1
    do_reset();
    step();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    chk("t2_ready_acc", 32'(cfg_ready), 32'h0);
    chk("t2_clk1_pre", 32'(clk_out[1]), 32'h0);
    step();
    chk("t2_ready_wait", 32'(cfg_ready), 32'h0);
    t2_clk  = 10'b1110011100;
    t2_tick = 10'b1000010000;
    for (int j = 0; j < 10; j++) begin
      step();
      chk("t2_clk1", 32'(clk_out[1]), 32'(t2_clk[9-j]));
      chk("t2_tick1", 32'(tick[1]), 32'(t2_tick[9-j]));
      dv = {4{def_clk(5 + j)}};
      chk("t2_clk_other", 32'(clk_out & 4'b1101), 32'(dv & 4'b1101));
      if (j == 0) chk("t2_ready_apply", 32'(cfg_ready), 32'h1);
    end

    // 3. stop ch2, then restart with div 2
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk("t3_ready_acc", 32'(cfg_ready), 32'h0);
    step(); step(); step();
    chk("t3_clk_e4", 32'(clk_out), 32'h0);
    step();
    chk("t3_ready_e5", 32'(cfg_ready), 32'h1);
    chk("t3_active_e5", 32'(active), 32'hB);
    chk("t3_clk_e5", 32'(clk_out), 32'hB);
    chk("t3_tick_e5", 32'(tick), 32'hB);
    for (int k = 6; k <= 8; k++) begin
      step();
      chk("t3_stop_clk2", 32'(clk_out[2]), 32'h0);
      chk("t3_stop_tick2", 32'(tick[2]), 32'h0);
      chk("t3_stop_active2", 32'(active[2]), 32'h0);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("t3_ready_acc2", 32'(cfg_ready), 32'h0);
    chk("t3_clk2_e9", 32'(clk_out[2]), 32'h0);
    t3_clk  = 4'b1010;
    t3_tick = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t3_clk2", 32'(clk_out[2]), 32'(t3_clk[3-j]));
      chk("t3_tick2", 32'(tick[2]), 32'(t3_tick[3-j]));
      if (j == 0) begin
        chk("t3_active_e10", 32'(active), 32'hF);
        chk("t3_ready_e10", 32'(cfg_ready), 32'h1);
`ifdef CLKDIV_ALIGN_EN
        chk("t3_tick_align", 32'(tick), 32'hF);
`else
        chk("t3_tick_e10", 32'(tick), 32'h4);
`endif
      end
      if (j == 1) begin
`ifdef CLKDIV_ALIGN_EN
        chk("t3_clk0_e11", 32'(clk_out[0]), 32'h1);
`else
        chk("t3_clk0_e11", 32'(clk_out[0]), 32'h0);
`endif
      end
    end

    // 4. back-to-back config to ch0: div 6 then div 3
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    step();
    cfg_div = 8'd3;
    chk("t4_ready_acc", 32'(cfg_ready), 32'h0);
    step(); step(); step();
    chk("t4_ready_hold", 32'(cfg_ready), 32'h0);
    t4_clk  = 12'b111000110110;
    t4_tick = 12'b100000100100;
    t4_rdy  = 12'b100000111111;
    for (int j = 0; j < 12; j++) begin
      step();
      if (j == 1) cfg_valid = 1'b0;
      chk("t4_clk0", 32'(clk_out[0]), 32'(t4_clk[11-j]));
      chk("t4_tick0", 32'(tick[0]), 32'(t4_tick[11-j]));
      chk("t4_ready", 32'(cfg_ready), 32'(t4_rdy[11-j]));
    end

    // 5. out-of-range channel on the NUM_CH=5 instance
    do_reset();
    step(); step();
    cfg_valid2 = 1'b1; cfg_ch2 = 3'd7; cfg_div2 = 8'd9;
    chk("t5_ready_pre", 32'(cfg_ready2), 32'h1);
    step();
    cfg_valid2 = 1'b0;
    chk("t5_ready_acc", 32'(cfg_ready2), 32'h1);
    chk("t5_clk_e3", 32'(clk_out2), 32'h0);
    for (int k = 4; k <= 11; k++) begin
      step();
      dv5 = {5{def_clk(k)}};
      chk("t5_clk", 32'(clk_out2), 32'(dv5));
      dv5 = {5{def_tick(k)}};
      chk("t5_tick", 32'(tick2), 32'(dv5));
      chk("t5_ready", 32'(cfg_ready2), 32'h1);
      chk("t5_active", 32'(active2), 32'h1F);
    end

    // 6. async reset while ch3 div 8 is pending
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    step();
    chk("t6_clk_pre", 32'(clk_out), 32'hF);
    chk("t6_ready_pre", 32'(cfg_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_clk_async", 32'(clk_out), 32'h0);
    chk("t6_tick_async", 32'(tick), 32'h0);
    chk("t6_ready_async", 32'(cfg_ready), 32'h1);
    step();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      dv = {4{def_clk(k)}};
      chk("t6_clk", 32'(clk_out), 32'(dv));
      dv = {4{def_tick(k)}};
      chk("t6_tick", 32'(tick), 32'(dv));
      chk("t6_ready", 32'(cfg_ready), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
